sr_uart_tx: RTL and testbench
=============================

# sr_uart_tx

Serial transmitter that drains the core's output word FIFO and sends each word over a UART line as DATA_WIDTH/8 bytes. Bytes go least-significant byte first, framed 8N1. The block sits directly downstream of the FIFO: it pulses the FIFO read enable, captures the word on the FIFO's registered read-data output, then serialises it. Its only outward connection is the `tx` pin plus a status flag.

## Interface
- DATA_WIDTH, 32: FIFO word width; must be a multiple of 8.
- CLKS_PER_BIT, 16: clock cycles per UART bit; minimum 2.
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  permits fetching new words; a word already in progress always completes.
- fifo_empty  input  1  upstream FIFO holds no data.
- fifo_rd_en  output  1  pop request to upstream FIFO, one-cycle pulse.
- fifo_rd_data  input  DATA_WIDTH  FIFO read data, valid the cycle after fifo_rd_en.
- tx  output  1  UART line, idle high.
- busy  output  1  high whenever state is not IDLE.

## Operation
- Reset values: tx=1, fifo_rd_en=0, busy=0, state=IDLE, all counters 0.
- States:
  - IDLE: fifo_rd_en = enable && !fifo_empty (combinational, IDLE only). If asserted, next state is FETCH.
  - FETCH: exactly 1 cycle. Load shift register from fifo_rd_data. Clear byte_cnt. Next state is START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. Shift right by 1 at each bit end. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then, if byte_cnt == DATA_WIDTH/8-1, go to IDLE; otherwise increment byte_cnt and go to START.
- Counters:
  - baud_cnt: $clog2(CLKS_PER_BIT) bits. Counts 0..CLKS_PER_BIT-1, wraps to 0, and restarts at 0 on every state entry.
  - bit_cnt: 3 bits. Wraps 7→0 on DATA exit.
  - byte_cnt: $clog2(DATA_WIDTH/8) bits, minimum 1.
- tx is registered and never glitches; it is driven high in IDLE and FETCH.
- At most one fifo_rd_en per word. fifo_rd_en is never asserted while fifo_empty=1, outside IDLE, or during reset.
- enable deasserted mid-word: the word completes, then the block stays in IDLE with fifo_rd_en=0.
- fifo_empty changing during FETCH or later has no effect; the captured word is sent as-is.
- reset mid-frame: at the next edge tx=1 and state=IDLE. The partial word is discarded and not refetched.

## Timing
- Cycle n: IDLE, fifo_rd_en=1.
- Cycle n+1: FETCH.
- Edge ending n+1: tx falls (start bit).
- Start-of-frame latency: 2 cycles from the rd_en cycle to tx=0.
- Frame length: 10*CLKS_PER_BIT cycles. Consecutive bytes of one word are back-to-back with no extra idle.
- Word length: (DATA_WIDTH/8)*10*CLKS_PER_BIT cycles, plus 2 cycles (IDLE + FETCH) between consecutive words. tx stays high during the gap.
- busy rises with the edge that leaves IDLE and falls with the edge that re-enters IDLE.

## Structure
- Shared header sr_uart_defs.vh holds:
  - state encodings (IDLE, FETCH, START, DATA, STOP; 3-bit localparams);
  - UART frame constants (8 data bits, 1 stop bit);
  - the default CLKS_PER_BIT.
  A future sr_uart_rx reuses it.
- One sub-module, sr_baud_tick:
  - counts to CLKS_PER_BIT-1 and pulses `tick` on the last cycle;
  - synchronous clear input used on every state entry.
- Top level contains the FSM, shift register, bit/byte counters and tx register.

## Test plan
All scenarios use CLKS_PER_BIT=4 and DATA_WIDTH=32 unless noted.

1. Reset then idle, fifo_empty=1 for 100 cycles → tx=1, busy=0, fifo_rd_en never asserted.
2. One word 0x44332211 → single fifo_rd_en pulse; tx falls 2 cycles later; bytes decoded 0x11, 0x22, 0x33, 0x44; 160 cycles from tx fall to IDLE; busy high the whole time.
3. Two queued words 0xA5A5A5A5, 0x0000FF01 → exactly 2 rd_en pulses; 2-cycle high gap between words; second word decodes as 0x01, 0xFF, 0x00, 0x00.
4. enable dropped during byte 1 of 0xDEADBEEF, FIFO non-empty → all 4 bytes 0xEF, 0xBE, 0xAD, 0xDE sent, then no further rd_en until enable=1.
5. reset asserted during DATA bit 3 of byte 2 → tx=1 and busy=0 at the next edge, no rd_en during reset; after release, the next word starts with a clean start bit.
6. CLKS_PER_BIT=2, fifo_empty toggling every cycle → no rd_en while empty; every bit exactly 2 cycles wide.

Source files
------------

// File: rtl/sr_uart_pkg.sv
// Shared UART definitions: FSM state encodings, 8N1 frame constants and the
// default bit period. Intended to be reused by a future receiver.
package sr_uart_pkg;

  localparam int UART_DATA_BITS       = 8;
  localparam int UART_STOP_BITS       = 1;
  localparam int DEFAULT_CLKS_PER_BIT = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4
  } uart_state_e;

  // Counter width for a range of n values; never narrower than one bit.
  function automatic int min1_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sr_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each bit. A synchronous clear holds it at zero so every timed state starts
// with a full bit period.
module sr_baud_tick
  import sr_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int            CNT_W = min1_clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // Free-running bit-period counter with synchronous clear and wrap.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/sr_uart_tx.sv
// UART transmitter draining a word FIFO: pops one word, then sends it as
// DATA_WIDTH/8 bytes, least-significant byte first, each framed 8N1.
module sr_uart_tx
  import sr_uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  tx,
  output logic                  busy
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int BYTE_W    = min1_clog2(NUM_BYTES);

  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NUM_BYTES - 1);
  localparam logic [2:0]        LAST_BIT  = 3'(UART_DATA_BITS - 1);

  // Elaboration-time guards on parameters the datapath relies on.
  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_bad_width
    $error("sr_uart_tx: DATA_WIDTH must be a non-zero multiple of 8");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("sr_uart_tx: CLKS_PER_BIT must be at least 2");
  end
  if (UART_DATA_BITS != 8 || UART_STOP_BITS != 1) begin : g_bad_frame
    $error("sr_uart_tx: only 8N1 framing is implemented");
  end

  uart_state_e           state;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [2:0]            bit_cnt;
  logic [BYTE_W-1:0]     byte_cnt;
  logic                  baud_clear;
  logic                  tick;

  // Pop request: only from IDLE, only with data available, never in reset.
  assign fifo_rd_en = (state == ST_IDLE) && enable && !fifo_empty && !reset;

  // The timer is parked at zero outside the timed states; timed states only
  // change on tick, where the counter wraps, so each state entry starts at 0.
  assign baud_clear = (state == ST_IDLE) || (state == ST_FETCH);

  sr_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk   (clk),
    .reset (reset),
    .clear (baud_clear),
    .tick  (tick)
  );

  // Transmit FSM with registered tx/busy, shift register and bit/byte counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      tx        <= 1'b1;
      busy      <= 1'b0;
      shift_reg <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fifo_rd_en) begin
            state <= ST_FETCH;
            busy  <= 1'b1;
          end
        end

        ST_FETCH: begin
          shift_reg <= fifo_rd_data;
          byte_cnt  <= '0;
          tx        <= 1'b0;
          state     <= ST_START;
        end

        ST_START: begin
          if (tick) begin
            tx      <= shift_reg[0];
            bit_cnt <= '0;
            state   <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (tick) begin
            shift_reg <= shift_reg >> 1;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              tx      <= 1'b1;
              state   <= ST_STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx      <= shift_reg[1];
            end
          end
        end

        ST_STOP: begin
          if (tick) begin
            if (byte_cnt == LAST_BYTE) begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
              tx       <= 1'b0;
              state    <= ST_START;
            end
          end
        end

        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_uart_tx.sv
// Directed bench for sr_uart_tx: a CLKS_PER_BIT=4 instance for the main
// scenarios and a CLKS_PER_BIT=2 instance fed by a FIFO whose empty flag
// toggles every cycle. Line activity is logged per cycle and decoded.
module tb_sr_uart_tx;

  localparam int DEPTH = 4096;

  logic clk;
  logic reset;
  logic enable4, enable2;

  logic        empty4, rd_en4, tx4, busy4;
  logic [31:0] rd_data4;
  logic        empty2, rd_en2, tx2, busy2;
  logic [31:0] rd_data2;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Bench FIFO models: words written by the stimulus, popped on rd_en.
  logic [31:0] mem4 [0:15];
  logic [31:0] mem2 [0:15];
  int wr4 = 0, rd_ptr4 = 0, wr2 = 0, rd_ptr2 = 0;
  logic tgl = 1'b0;

  // Per-cycle traces and event logs.
  logic tx_tr4   [0:DEPTH-1];
  logic busy_tr4 [0:DEPTH-1];
  logic tx_tr2   [0:DEPTH-1];
  int rd_cyc4[$];
  int rd_cyc2[$];
  int bad_rd4 = 0, bad_rd2 = 0;
  int n_low4 = 0, n_busy4 = 0;

  sr_uart_tx #(.DATA_WIDTH(32), .CLKS_PER_BIT(4)) dut4 (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable4),
    .fifo_empty   (empty4),
    .fifo_rd_en   (rd_en4),
    .fifo_rd_data (rd_data4),
    .tx           (tx4),
    .busy         (busy4)
  );

  sr_uart_tx #(.DATA_WIDTH(32), .CLKS_PER_BIT(2)) dut2 (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable2),
    .fifo_empty   (empty2),
    .fifo_rd_en   (rd_en2),
    .fifo_rd_data (rd_data2),
    .tx           (tx2),
    .busy         (busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign empty4 = (rd_ptr4 == wr4);
  assign empty2 = tgl || (rd_ptr2 == wr2);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    tgl <= ~tgl;
    if (rd_en4) begin
      rd_data4 <= mem4[rd_ptr4 % 16];
      rd_ptr4  <= rd_ptr4 + 1;
    end
    if (rd_en2) begin
      rd_data2 <= mem2[rd_ptr2 % 16];
      rd_ptr2  <= rd_ptr2 + 1;
    end
  end

  always @(negedge clk) begin
    if (cyc < DEPTH) begin
      tx_tr4[cyc]   = tx4;
      busy_tr4[cyc] = busy4;
      tx_tr2[cyc]   = tx2;
    end
    if (tx4 === 1'b0) n_low4++;
    if (busy4 === 1'b1) n_busy4++;
    if (rd_en4 === 1'b1) begin
      rd_cyc4.push_back(cyc);
      if (empty4 || reset) bad_rd4++;
    end
    if (rd_en2 === 1'b1) begin
      rd_cyc2.push_back(cyc);
      if (empty2 || reset) bad_rd2++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic tr(input bit d2, input int c);
    if (c < 0 || c >= DEPTH) return 1'bx;
    return d2 ? tx_tr2[c] : tx_tr4[c];
  endfunction

  function automatic int find_fall(input bit d2, input int from);
    for (int c = from + 1; c < from + 300; c++) begin
      if (tr(d2, c) === 1'b0 && tr(d2, c - 1) === 1'b1) return c;
    end
    return -1000;
  endfunction

  // Sample each data bit mid-period; byte b of the word starting at fall f.
  function automatic logic [7:0] decode(input bit d2, input int f, input int b);
    int cpb;
    int base;
    logic [7:0] v;
    cpb  = d2 ? 2 : 4;
    base = f + b * 10 * cpb;
    for (int k = 0; k < 8; k++) v[k] = tr(d2, base + cpb * (1 + k) + cpb / 2);
    return v;
  endfunction

  function automatic int count_busy(input int from, input int to);
    int n = 0;
    for (int c = from; c <= to; c++) begin
      if (c >= 0 && c < DEPTH && busy_tr4[c] === 1'b1) n++;
    end
    return n;
  endfunction

  initial begin
    int r, f, f1, f2, target, n_low_s, n_busy_s, misalign;

    reset   = 1'b1;
    enable4 = 1'b1;
    enable2 = 1'b1;
    repeat (3) step();

    // Reset state.
    check("reset_tx",    {31'd0, tx4},    32'd1);
    check("reset_busy",  {31'd0, busy4},  32'd0);
    check("reset_rd_en", {31'd0, rd_en4}, 32'd0);
    check("reset_tx2",   {31'd0, tx2},    32'd1);
    reset = 1'b0;

    // 1: idle with an empty FIFO for 100 cycles.
    n_low_s  = n_low4;
    n_busy_s = n_busy4;
    repeat (100) step();
    check("idle_rd_count",  32'(rd_cyc4.size()),    32'd0);
    check("idle_tx_low",    32'(n_low4 - n_low_s),  32'd0);
    check("idle_busy_high", 32'(n_busy4 - n_busy_s), 32'd0);

    // 2: single word.
    mem4[wr4 % 16] = 32'h4433_2211;
    wr4++;
    repeat (200) step();
    check("w1_rd_count", 32'(rd_cyc4.size()), 32'd1);
    r = (rd_cyc4.size() > 0) ? rd_cyc4[0] : 0;
    f = find_fall(1'b0, r);
    check("w1_latency", 32'(f - r), 32'd2);
    check("w1_byte0", {24'd0, decode(1'b0, f, 0)}, 32'h11);
    check("w1_byte1", {24'd0, decode(1'b0, f, 1)}, 32'h22);
    check("w1_byte2", {24'd0, decode(1'b0, f, 2)}, 32'h33);
    check("w1_byte3", {24'd0, decode(1'b0, f, 3)}, 32'h44);
    check("w1_busy_window", 32'(count_busy(r + 1, f + 159)), 32'd161);
    check("w1_busy_fall", {31'd0, busy_tr4[f + 160]}, 32'd0);

    // 3: two queued words.
    mem4[wr4 % 16] = 32'hA5A5_A5A5;
    wr4++;
    mem4[wr4 % 16] = 32'h0000_FF01;
    wr4++;
    repeat (360) step();
    check("w23_rd_count", 32'(rd_cyc4.size()), 32'd3);
    f1 = (rd_cyc4.size() > 1) ? find_fall(1'b0, rd_cyc4[1]) : 0;
    f2 = (rd_cyc4.size() > 2) ? find_fall(1'b0, rd_cyc4[2]) : 0;
    check("w23_spacing", 32'(f2 - f1), 32'd162);
    check("w23_gap_high", {31'd0, tr(1'b0, f1 + 160) & tr(1'b0, f1 + 161)}, 32'd1);
    check("w2_byte0", {24'd0, decode(1'b0, f1, 0)}, 32'hA5);
    check("w2_byte3", {24'd0, decode(1'b0, f1, 3)}, 32'hA5);
    check("w3_byte0", {24'd0, decode(1'b0, f2, 0)}, 32'h01);
    check("w3_byte1", {24'd0, decode(1'b0, f2, 1)}, 32'hFF);
    check("w3_byte2", {24'd0, decode(1'b0, f2, 2)}, 32'h00);
    check("w3_byte3", {24'd0, decode(1'b0, f2, 3)}, 32'h00);

    // 4: enable dropped during byte 1, FIFO still holding a word.
    mem4[wr4 % 16] = 32'hDEAD_BEEF;
    wr4++;
    mem4[wr4 % 16] = 32'h1234_5678;
    wr4++;
    for (int i = 0; i < 20 && rd_cyc4.size() < 4; i++) step();
    check("w4_rd_seen", 32'(rd_cyc4.size()), 32'd4);
    r = (rd_cyc4.size() > 3) ? rd_cyc4[3] : cyc;
    target = r + 2 + 50;
    for (int i = 0; i < 100 && cyc < target; i++) step();
    enable4 = 1'b0;
    repeat (250) step();
    f = find_fall(1'b0, r);
    check("w4_rd_count", 32'(rd_cyc4.size()), 32'd4);
    check("w4_byte0", {24'd0, decode(1'b0, f, 0)}, 32'hEF);
    check("w4_byte1", {24'd0, decode(1'b0, f, 1)}, 32'hBE);
    check("w4_byte2", {24'd0, decode(1'b0, f, 2)}, 32'hAD);
    check("w4_byte3", {24'd0, decode(1'b0, f, 3)}, 32'hDE);
    check("w4_idle_busy", {31'd0, busy4}, 32'd0);
    check("w4_fifo_left", 32'(wr4 - rd_ptr4), 32'd1);

    // 5: re-enable, then reset during DATA bit 3 of byte 2.
    enable4 = 1'b1;
    for (int i = 0; i < 20 && rd_cyc4.size() < 5; i++) step();
    check("w5_rd_seen", 32'(rd_cyc4.size()), 32'd5);
    r = (rd_cyc4.size() > 4) ? rd_cyc4[4] : cyc;
    repeat (4) step();
    f = find_fall(1'b0, r);
    mem4[wr4 % 16] = 32'h0000_00A5;
    wr4++;
    target = f + 97;
    for (int i = 0; i < 200 && cyc < target; i++) step();
    check("w5_at_bit3", 32'(cyc), 32'(target));
    check("w5_tx_before_reset", {31'd0, tx4}, 32'd0);
    reset = 1'b1;
    step();
    check("w5_tx_after_reset",   {31'd0, tx4},   32'd1);
    check("w5_busy_after_reset", {31'd0, busy4}, 32'd0);
    repeat (2) step();
    check("w5_no_rd_in_reset", 32'(rd_cyc4.size()), 32'd5);
    reset = 1'b0;
    repeat (200) step();
    check("w6_rd_count", 32'(rd_cyc4.size()), 32'd6);
    r = (rd_cyc4.size() > 5) ? rd_cyc4[5] : 0;
    f = find_fall(1'b0, r);
    check("w6_latency", 32'(f - r), 32'd2);
    check("w6_clean_start",
          {26'd0, tr(1'b0, f - 1), tr(1'b0, f), tr(1'b0, f + 1),
           tr(1'b0, f + 2), tr(1'b0, f + 3), tr(1'b0, f + 4)}, 32'b100001);
    check("w6_byte0", {24'd0, decode(1'b0, f, 0)}, 32'hA5);
    check("w6_byte1", {24'd0, decode(1'b0, f, 1)}, 32'h00);
    check("dut4_no_bad_rd", 32'(bad_rd4), 32'd0);

    // 6: CLKS_PER_BIT=2 with fifo_empty toggling every cycle.
    mem2[wr2 % 16] = 32'h96C3_5A0F;
    wr2++;
    repeat (150) step();
    check("b2_rd_count", 32'(rd_cyc2.size()), 32'd1);
    check("b2_no_bad_rd", 32'(bad_rd2), 32'd0);
    r = (rd_cyc2.size() > 0) ? rd_cyc2[0] : 0;
    f = find_fall(1'b1, r);
    check("b2_latency", 32'(f - r), 32'd2);
    check("b2_byte0", {24'd0, decode(1'b1, f, 0)}, 32'h0F);
    check("b2_byte1", {24'd0, decode(1'b1, f, 1)}, 32'h5A);
    check("b2_byte2", {24'd0, decode(1'b1, f, 2)}, 32'hC3);
    check("b2_byte3", {24'd0, decode(1'b1, f, 3)}, 32'h96);
    misalign = 0;
    for (int c = f + 1; c <= f + 80; c++) begin
      if (tr(1'b1, c) !== tr(1'b1, c - 1) && ((c - f) % 2) != 0) misalign++;
    end
    check("b2_bit_width", 32'(misalign), 32'd0);
    check("b2_end_idle", {31'd0, tr(1'b1, f + 80) & ~busy2}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
